// File: rtl/loadblock_banked.sv
// loadblock_banked: banked load path between the MEM stage / VLSU and four
// synchronous data-memory banks. One scalar or vector (up to 4 elements) load
// per transaction. Same-bank elements are served in rounds, lowest element
// index first. Scalar results are aligned and extended onto rsp_data0.
//
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned or
// reserved-width scalar loads with rsp_err instead of accessing the banks.
//
// state  | meaning
// IDLE   | ready for a request; latches all request fields on accept
// ISSUE  | one cycle: drive bank_en/bank_row for this round's grants
// WAIT   | count bank read latency; capture granted bank data on last count
// RESP   | hold response until rsp_ready

module loadblock_banked #(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_vector,
  input  logic [2:0]        load_select,
  input  logic [ADDR_W+1:0] scalar_addr,
  input  logic [2:0]        elem_cnt,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  output logic [3:0]        bank_en,
  output logic [ADDR_W-3:0] bank_row0,
  output logic [ADDR_W-3:0] bank_row1,
  output logic [ADDR_W-3:0] bank_row2,
  output logic [ADDR_W-3:0] bank_row3,
  input  logic [31:0]       bank_rdata0,
  input  logic [31:0]       bank_rdata1,
  input  logic [31:0]       bank_rdata2,
  input  logic [31:0]       bank_rdata3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data0,
  output logic [31:0]       rsp_data1,
  output logic [31:0]       rsp_data2,
  output logic [31:0]       rsp_data3,
  output logic [3:0]        rsp_mask,
  output logic              rsp_err
);

  localparam int ROW_W = ADDR_W - 2;
  // WAIT runs RD_LAT cycles: the down-counter is loaded with RD_LAT-1 and
  // capture happens when it reads zero.
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // latched request
  logic             is_vec_q;
  logic [2:0]       sel_q;
  logic [1:0]       off_q;
  logic [ROW_W-1:0] row_q  [4];
  logic [1:0]       bank_q [4];

  // round bookkeeping
  logic [3:0]       pend_q;
  logic [3:0]       gnt_vld_q;
  logic [1:0]       gnt_idx_q [4];
  logic [1:0]       cnt_q;

  // response registers
  logic [31:0]      data_q [4];
  logic [3:0]       mask_q;

  // combinational helpers
  logic [ADDR_W-1:0] addr_in  [4];
  logic [31:0]       rdata_in [4];
  logic [3:0]        gnt_vld;
  logic [1:0]        gnt_idx [4];
  logic [ROW_W-1:0]  row_c   [4];
  logic [ROW_W-1:0]  row_o   [4];
  logic [3:0]        acc_pend;
  logic [3:0]        clr_mask;
  logic              last_cnt;

  // Scalar word index is truncated to the bank row width; the top bits of
  // the byte address do not select anything in a single bank.
  logic unused_scalar_hi;
  assign unused_scalar_hi = ^scalar_addr[ADDR_W+1:ADDR_W];

  assign addr_in[0]  = addr0;
  assign addr_in[1]  = addr1;
  assign addr_in[2]  = addr2;
  assign addr_in[3]  = addr3;
  assign rdata_in[0] = bank_rdata0;
  assign rdata_in[1] = bank_rdata1;
  assign rdata_in[2] = bank_rdata2;
  assign rdata_in[3] = bank_rdata3;

  // Little-endian byte select followed by sign/zero extension.
  function automatic logic [31:0] align_scalar(input logic [31:0] rd,
                                               input logic [1:0]  off,
                                               input logic [2:0]  sel);
    logic [31:0] w;
    w = rd >> {off, 3'b000};
    case (sel)
      3'b000:  align_scalar = {{24{w[7]}}, w[7:0]};
      3'b001:  align_scalar = {{16{w[15]}}, w[15:0]};
      3'b010:  align_scalar = w;
      3'b100:  align_scalar = {24'd0, w[7:0]};
      3'b101:  align_scalar = {16'd0, w[15:0]};
      default: align_scalar = 32'd0;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic acc_err;
  logic err_q;

  function automatic logic trap_check(input logic [2:0] sel, input logic [1:0] off);
    case (sel)
      3'b000, 3'b100: trap_check = 1'b0;
      3'b001, 3'b101: trap_check = off[0];
      3'b010:         trap_check = (off != 2'd0);
      default:        trap_check = 1'b1;
    endcase
  endfunction

  assign acc_err = !req_is_vector && trap_check(load_select, scalar_addr[1:0]);
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Initial pending mask of an incoming request.
  always_comb begin
    acc_pend = 4'b0001;
    if (req_is_vector) begin
      for (int e = 0; e < 4; e++) begin
        acc_pend[e] = (elem_cnt > 3'(e));
      end
    end
`ifdef MISALIGN_TRAP_EN
    else if (acc_err) begin
      acc_pend = 4'b0000;
    end
`endif
  end

  // Per-bank grant: lowest-index pending element that maps to the bank.
  always_comb begin
    gnt_vld = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      gnt_idx[b] = 2'd0;
      for (int e = 3; e >= 0; e--) begin
        if (pend_q[e] && (bank_q[e] == 2'(b))) begin
          gnt_vld[b] = 1'b1;
          gnt_idx[b] = 2'(e);
        end
      end
      row_c[b] = row_q[gnt_idx[b]];
    end
  end

  // Elements completed by the round whose data is being captured.
  always_comb begin
    clr_mask = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      if (gnt_vld_q[b]) begin
        clr_mask[gnt_idx_q[b]] = 1'b1;
      end
    end
  end

  assign last_cnt = (cnt_q == 2'd0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_d   = state_q;
    bank_en   = 4'b0000;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      row_o[b] = '0;
    end
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = (acc_pend == 4'b0000) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        bank_en = gnt_vld;
        for (int b = 0; b < 4; b++) begin
          if (gnt_vld[b]) begin
            row_o[b] = row_c[b];
          end
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (last_cnt) begin
          state_d = ((pend_q & ~clr_mask) != 4'b0000) ? S_ISSUE : S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bank_row0 = row_o[0];
  assign bank_row1 = row_o[1];
  assign bank_row2 = row_o[2];
  assign bank_row3 = row_o[3];

  assign rsp_data0 = data_q[0];
  assign rsp_data1 = data_q[1];
  assign rsp_data2 = data_q[2];
  assign rsp_data3 = data_q[3];
  assign rsp_mask  = mask_q;

  // Request latch, round bookkeeping and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_vec_q  <= 1'b0;
      sel_q     <= 3'd0;
      off_q     <= 2'd0;
      pend_q    <= 4'b0000;
      gnt_vld_q <= 4'b0000;
      cnt_q     <= 2'd0;
      mask_q    <= 4'b0000;
`ifdef MISALIGN_TRAP_EN
      err_q     <= 1'b0;
`endif
      for (int e = 0; e < 4; e++) begin
        row_q[e]     <= '0;
        bank_q[e]    <= 2'd0;
        gnt_idx_q[e] <= 2'd0;
        data_q[e]    <= 32'd0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            is_vec_q <= req_is_vector;
            sel_q    <= load_select;
            off_q    <= scalar_addr[1:0];
            pend_q   <= acc_pend;
            mask_q   <= 4'b0000;
`ifdef MISALIGN_TRAP_EN
            err_q    <= acc_err;
`endif
            for (int e = 0; e < 4; e++) begin
              row_q[e]  <= addr_in[e][ADDR_W-1:2];
              bank_q[e] <= addr_in[e][1:0];
              data_q[e] <= 32'd0;
            end
            // a scalar is always element 0 on bank 0, row = word index
            if (!req_is_vector) begin
              row_q[0]  <= scalar_addr[ROW_W+1:2];
              bank_q[0] <= 2'd0;
            end
          end
        end
        S_ISSUE: begin
          gnt_vld_q <= gnt_vld;
          gnt_idx_q <= gnt_idx;
          cnt_q     <= LAT_LOAD;
        end
        S_WAIT: begin
          if (last_cnt) begin
            for (int b = 0; b < 4; b++) begin
              if (gnt_vld_q[b]) begin
                data_q[gnt_idx_q[b]] <= is_vec_q ? rdata_in[b]
                                                 : align_scalar(rdata_in[b], off_q, sel_q);
                mask_q[gnt_idx_q[b]] <= 1'b1;
              end
            end
            pend_q <= pend_q & ~clr_mask;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_loadblock_banked.sv
// Testbench for loadblock_banked: directed cases plus randomized loads,
// checked against a transaction-level reference model through a scoreboard.
module tb_loadblock_banked;
  localparam int ADDR_W = 11;
  localparam int RD_LAT = 1;
  localparam int ROW_W  = ADDR_W - 2;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_is_vector;
  logic [2:0] load_select;
  logic [ADDR_W+1:0] scalar_addr;
  logic [2:0] elem_cnt;
  logic [ADDR_W-1:0] addr0, addr1, addr2, addr3;
  logic [3:0] bank_en;
  logic [ROW_W-1:0] bank_row0, bank_row1, bank_row2, bank_row3;
  logic [31:0] bank_rdata0, bank_rdata1, bank_rdata2, bank_rdata3;
  logic rsp_valid, rsp_ready;
  logic [31:0] rsp_data0, rsp_data1, rsp_data2, rsp_data3;
  logic [3:0] rsp_mask;
  logic rsp_err;

  loadblock_banked #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_vector(req_is_vector),
    .load_select(load_select), .scalar_addr(scalar_addr), .elem_cnt(elem_cnt),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .bank_en(bank_en),
    .bank_row0(bank_row0), .bank_row1(bank_row1), .bank_row2(bank_row2), .bank_row3(bank_row3),
    .bank_rdata0(bank_rdata0), .bank_rdata1(bank_rdata1),
    .bank_rdata2(bank_rdata2), .bank_rdata3(bank_rdata3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_data3(rsp_data3),
    .rsp_mask(rsp_mask), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- bank memory model ----------------
  logic [31:0] mem [4][512];
  logic [31:0] pipe [4][RD_LAT];
  logic [ROW_W-1:0] row_w [4];
  assign row_w[0] = bank_row0;
  assign row_w[1] = bank_row1;
  assign row_w[2] = bank_row2;
  assign row_w[3] = bank_row3;

  // data appears RD_LAT cycles after bank_en; otherwise garbage
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      pipe[b][0] <= bank_en[b] ? mem[b][row_w[b]] : $urandom;
      for (int s = 1; s < RD_LAT; s++) pipe[b][s] <= pipe[b][s-1];
    end
  end
  assign bank_rdata0 = pipe[0][RD_LAT-1];
  assign bank_rdata1 = pipe[1][RD_LAT-1];
  assign bank_rdata2 = pipe[2][RD_LAT-1];
  assign bank_rdata3 = pipe[3][RD_LAT-1];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0][31:0] d;
    logic [3:0]       mask;
    logic             err;
    int unsigned      acc;
    int unsigned      lat;
    int unsigned      hold;
  } exp_t;

  exp_t sb[$];
  logic [ROW_W-1:0] q_row0[$], q_row1[$], q_row2[$], q_row3[$];

  task automatic push_row(input int b, input logic [ROW_W-1:0] r);
    case (b)
      0: q_row0.push_back(r);
      1: q_row1.push_back(r);
      2: q_row2.push_back(r);
      default: q_row3.push_back(r);
    endcase
  endtask

  task automatic pop_row(input int b, output logic ok, output logic [ROW_W-1:0] r);
    ok = 1'b0; r = '0;
    case (b)
      0: if (q_row0.size() > 0) begin ok = 1'b1; r = q_row0.pop_front(); end
      1: if (q_row1.size() > 0) begin ok = 1'b1; r = q_row1.pop_front(); end
      2: if (q_row2.size() > 0) begin ok = 1'b1; r = q_row2.pop_front(); end
      default: if (q_row3.size() > 0) begin ok = 1'b1; r = q_row3.pop_front(); end
    endcase
  endtask

  task automatic flush_all();
    sb.delete();
    q_row0.delete(); q_row1.delete(); q_row2.delete(); q_row3.delete();
  endtask

  // reference scalar result built byte by byte
  function automatic logic [31:0] scalar_ref(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] sel);
    int unsigned by [4];
    int unsigned s [4];
    int unsigned h;
    for (int k = 0; k < 4; k++) by[k] = (word >> (8 * k)) & 32'hFF;
    for (int k = 0; k < 4; k++) s[k] = (int'(off) + k < 4) ? by[int'(off) + k] : 0;
    h = s[0] + 256 * s[1];
    case (sel)
      3'd0: return (s[0] >= 128) ? s[0] + 32'hFFFF_FF00 : s[0];
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd2: return s[0] + 256 * s[1] + 65536 * s[2] + 16777216 * s[3];
      3'd4: return s[0];
      3'd5: return h;
      default: return 32'd0;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic bit trap_ref(input logic [2:0] sel, input logic [1:0] off);
    if (sel == 3'd3 || sel >= 3'd6) return 1'b1;
    if ((sel == 3'd1 || sel == 3'd5) && off[0]) return 1'b1;
    if (sel == 3'd2 && off != 2'd0) return 1'b1;
    return 1'b0;
  endfunction
`endif

  // ---------------- driver ----------------
  logic in_reset = 1'b0;

  task automatic issue(input logic v, input logic [2:0] sel, input logic [ADDR_W+1:0] sa,
                       input logic [2:0] cnt, input logic [3:0][ADDR_W-1:0] a,
                       input int unsigned hold);
    exp_t x;
    int cntb [4];
    int rounds;
    int guard;
    @(negedge clk);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    x = '0;
    for (int b = 0; b < 4; b++) cntb[b] = 0;
    if (v) begin
      for (int e = 0; e < 4; e++) begin
        if (e < int'(cnt)) begin
          x.d[e] = mem[a[e][1:0]][a[e][ADDR_W-1:2]];
          x.mask[e] = 1'b1;
          push_row(int'(a[e][1:0]), a[e][ADDR_W-1:2]);
          cntb[a[e][1:0]]++;
        end
      end
    end else begin
`ifdef MISALIGN_TRAP_EN
      if (trap_ref(sel, sa[1:0])) begin
        x.err = 1'b1;
      end else
`endif
      begin
        x.mask = 4'b0001;
        x.d[0] = scalar_ref(mem[0][sa[ROW_W+1:2]], sa[1:0], sel);
        push_row(0, sa[ROW_W+1:2]);
        cntb[0] = 1;
      end
    end
    rounds = 0;
    for (int b = 0; b < 4; b++) if (cntb[b] > rounds) rounds = cntb[b];
    x.lat  = (rounds == 0) ? 1 : 2 + RD_LAT + (rounds - 1) * (1 + RD_LAT);
    x.acc  = cyc;
    x.hold = hold;
    sb.push_back(x);
    req_valid = 1'b1; req_is_vector = v; load_select = sel; scalar_addr = sa;
    elem_cnt = cnt; addr0 = a[0]; addr1 = a[1]; addr2 = a[2]; addr3 = a[3];
    @(negedge clk);
    req_valid = 1'b0;
    req_is_vector = 1'($urandom); load_select = 3'($urandom); scalar_addr = 13'($urandom);
    elem_cnt = 3'($urandom); addr0 = 11'($urandom); addr1 = 11'($urandom);
    addr2 = 11'($urandom); addr3 = 11'($urandom);
  endtask

  // ---------------- monitors ----------------
  logic seen = 1'b0;
  logic chk_idle = 1'b0;
  int unsigned hold_cnt = 0;
  logic bm_ok;
  logic [ROW_W-1:0] bm_row;

  always @(negedge clk) begin
    if (!in_reset) begin
      for (int b = 0; b < 4; b++) begin
        if (bank_en[b]) begin
          pop_row(b, bm_ok, bm_row);
          if (!bm_ok) check("bank_en_unexpected", {28'd0, bank_en}, 32'd0);
          else check($sformatf("bank_row%0d", b), {23'd0, row_w[b]}, {23'd0, bm_row});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (in_reset) begin
      rsp_ready = 1'b0;
      seen = 1'b0;
      chk_idle = 1'b0;
    end else if (rsp_valid) begin
      chk_idle = 1'b0;
      if (sb.size() == 0) begin
        check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b1;
      end else begin
        exp_t x;
        x = sb[0];
        if (!seen) begin
          check("latency", cyc - x.acc, x.lat);
          seen = 1'b1;
          hold_cnt = x.hold;
        end
        check("rsp_data0", rsp_data0, x.d[0]);
        check("rsp_data1", rsp_data1, x.d[1]);
        check("rsp_data2", rsp_data2, x.d[2]);
        check("rsp_data3", rsp_data3, x.d[3]);
        check("rsp_mask", {28'd0, rsp_mask}, {28'd0, x.mask});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, x.err});
        check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
        if (hold_cnt > 0) begin
          rsp_ready = 1'b0;
          hold_cnt--;
        end else begin
          rsp_ready = ($urandom_range(0, 2) != 0);
        end
        if (rsp_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
          chk_idle = 1'b1;
        end
      end
    end else begin
      if (chk_idle) check("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
      chk_idle = 1'b0;
      rsp_ready = 1'($urandom);
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_bank_en"}, {28'd0, bank_en}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_mask"}, {28'd0, rsp_mask}, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_rsp_data0"}, rsp_data0, 32'd0);
    check({tag, "_rsp_data1"}, rsp_data1, 32'd0);
    check({tag, "_rsp_data2"}, rsp_data2, 32'd0);
    check({tag, "_rsp_data3"}, rsp_data3, 32'd0);
    check({tag, "_rows"}, {5'd0, bank_row0, bank_row1, bank_row2}, 32'd0);
    check({tag, "_row3"}, {23'd0, bank_row3}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [3:0][ADDR_W-1:0] a;
    int guard;
    rst = 1'b1; req_valid = 1'b0; req_is_vector = 1'b0; load_select = 3'd0;
    scalar_addr = '0; elem_cnt = 3'd0; addr0 = '0; addr1 = '0; addr2 = '0; addr3 = '0;
    in_reset = 1'b1;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 512; r++) mem[b][r] = $urandom;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    in_reset = 1'b0;

    // lb at byte 0x006: bank0 row1, byte 2
    mem[0][1] = 32'h80FF_1234;
    issue(1'b0, 3'b000, 13'h006, 3'd0, '0, 0);
    // lhu at offset 2
    mem[0][5] = 32'hBEEF_0001;
    issue(1'b0, 3'b101, 13'h016, 3'd0, '0, 0);
    // four elements, one per bank
    issue(1'b1, 3'd0, '0, 3'd4, {11'd7, 11'd6, 11'd5, 11'd4}, 0);
    // three elements on bank 0
    issue(1'b1, 3'd0, '0, 3'd3, {11'd0, 11'd8, 11'd4, 11'd0}, 0);
    // consumer back-pressure, then an empty vector
    issue(1'b1, 3'd0, '0, 3'd4, {11'd13, 11'd9, 11'd2, 11'd3}, 5);
    issue(1'b1, 3'd0, '0, 3'd0, {11'd1, 11'd2, 11'd3, 11'd4}, 0);

    // reset during the second WAIT round of a conflicting vector
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
    mem[0][0] = 32'hA5A5_0F0F;
    issue(1'b1, 3'd0, '0, 3'd3, {11'd0, 11'd8, 11'd4, 11'd0}, 0);
    repeat (3) @(negedge clk);
    in_reset = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    rst = 1'b0;
    flush_all();
    in_reset = 1'b0;
    repeat (8) @(negedge clk);

`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 13'h005, 3'd0, '0, 0);
    issue(1'b0, 3'b001, 13'h023, 3'd0, '0, 0);
    issue(1'b0, 3'b111, 13'h020, 3'd0, '0, 0);
`endif

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++)
        a[i] = ($urandom_range(0, 2) == 0) ? 11'($urandom_range(0, 15)) : 11'($urandom);
      issue(1'($urandom), 3'($urandom), 13'($urandom), 3'($urandom_range(0, 4)), a,
            ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 500) begin @(negedge clk); guard++; end
    repeat (4) @(negedge clk);
    check("drain_responses", sb.size(), 32'd0);
    check("rows_left", q_row0.size() + q_row1.size() + q_row2.size() + q_row3.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
